mtimer_irq_gen: RTL and testbench

// Memory-mapped machine timer that drives the core's timer_interrupt input.
// It holds a 64-bit mtime counter, a 64-bit mtimecmp register, a control register and a prescale register.
// It responds on the same word-access load/store bus the core's data memory uses.
// It raises a level interrupt when mtime >= mtimecmp while enabled.

---
 rtl/mtimer_irq_gen.sv | 126 ++++++++++++
 tb/tb_mtimer_irq_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mtimer_irq_gen.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, control and prescale
// registers on the core's word load/store bus, with a registered timer interrupt.
module mtimer_irq_gen #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [31:0] rdata,
    output logic        timer_interrupt
);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_PRESCALE = 3'd5;

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcount;

    logic       hit;
    logic [2:0] offset;
    logic       wr_hit;
    logic       tick;
    logic       due;

    assign offset = addr[4:2];
    assign hit    = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
    assign wr_hit = hit && wr_en;
    assign due    = en && (mtime >= mtimecmp);

    // Prescaler fires a tick on the cycle its counter matches the prescale value
    always_comb begin
        tick = 1'b0;
        if (en && (pcount == prescale)) begin
            tick = 1'b1;
        end
    end

    // Load data mux; idle, missed or misaligned accesses return zero
    always_comb begin
        rdata = 32'h0;
        if (hit && rd_en) begin
            case (offset)
                OFF_MTIME_LO: rdata = mtime[31:0];
                OFF_MTIME_HI: rdata = mtime[63:32];
                OFF_CMP_LO:   rdata = mtimecmp[31:0];
                OFF_CMP_HI:   rdata = mtimecmp[63:32];
                OFF_CTRL:     rdata = {30'h0, timer_interrupt, en};
                OFF_PRESCALE: rdata = 32'(prescale);
                default:      rdata = 32'h0;
            endcase
        end
    end

    // Prescale counter: runs while enabled, restarts on a match or a prescale store
    always_ff @(posedge clk) begin
        if (rst) begin
            pcount <= '0;
        end else if (wr_hit && (offset == OFF_PRESCALE)) begin
            pcount <= '0;
        end else if (tick) begin
            pcount <= '0;
        end else if (en) begin
            pcount <= pcount + 1'b1;
        end
    end

    // mtime: a store to either half beats the tick increment in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= 64'h0;
        end else if (wr_hit && (offset == OFF_MTIME_LO)) begin
            mtime[31:0] <= wdata;
        end else if (wr_hit && (offset == OFF_MTIME_HI)) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp halves are written independently
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_hit && (offset == OFF_CMP_LO)) begin
            mtimecmp[31:0] <= wdata;
        end else if (wr_hit && (offset == OFF_CMP_HI)) begin
            mtimecmp[63:32] <= wdata;
        end
    end

    // Control and prescale registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            prescale <= '0;
        end else begin
            if (wr_hit && (offset == OFF_CTRL)) begin
                en <= wdata[0];
            end
            if (wr_hit && (offset == OFF_PRESCALE)) begin
                prescale <= wdata[PRESCALE_W-1:0];
            end
        end
    end

    // Interrupt follows the pre-update compare one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= due;
        end
    end

endmodule

// File: tb/tb_mtimer_irq_gen.sv
// Directed bench for mtimer_irq_gen: register readback table plus
// hand-written sequences for counting, carry, interrupt, prescale and reset.
module tb_mtimer_irq_gen;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rdata;
    logic        timer_interrupt;

    int n_cmp;
    int n_bad;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic        rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[11];

    mtimer_irq_gen #(
        .BASE_ADDR (BASE),
        .PRESCALE_W(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .wdata          (wdata),
        .rd_en          (rd_en),
        .wr_en          (wr_en),
        .rdata          (rdata),
        .timer_interrupt(timer_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic r,
                      output logic [31:0] d);
        addr  = a;
        rd_en = r;
        #1;
        d     = rdata;
        rd_en = 1'b0;
        addr  = 32'h0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a,
                            input logic [31:0] exp);
        logic [31:0] d;
        rd(a, 1'b1, d);
        check(name, d, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 11; i++) begin
            rd(tbl[i].a, tbl[i].rd, d);
            check({tag, "/", tbl[i].name}, d, tbl[i].exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        addr  = 32'h0;
        wdata = 32'h0;
        rd_en = 1'b0;
        wr_en = 1'b0;

        tbl[0]  = '{"mtime_lo",   BASE + 32'h00, 1'b1, 32'h0};
        tbl[1]  = '{"mtime_hi",   BASE + 32'h04, 1'b1, 32'h0};
        tbl[2]  = '{"cmp_lo",     BASE + 32'h08, 1'b1, 32'hFFFF_FFFF};
        tbl[3]  = '{"cmp_hi",     BASE + 32'h0C, 1'b1, 32'hFFFF_FFFF};
        tbl[4]  = '{"ctrl",       BASE + 32'h10, 1'b1, 32'h0};
        tbl[5]  = '{"prescale",   BASE + 32'h14, 1'b1, 32'h0};
        tbl[6]  = '{"rsv18",      BASE + 32'h18, 1'b1, 32'h0};
        tbl[7]  = '{"rsv1c",      BASE + 32'h1C, 1'b1, 32'h0};
        tbl[8]  = '{"outside48",  BASE + 32'h48, 1'b1, 32'h0};
        tbl[9]  = '{"misalign0a", BASE + 32'h0A, 1'b1, 32'h0};
        tbl[10] = '{"no_rd_en",   BASE + 32'h08, 1'b0, 32'h0};

        // 1: reset state
        cycles(2);
        do_reset();
        check("rst_irq", {31'h0, timer_interrupt}, 32'h0);
        run_table("reset");

        // 2: free run at prescale 0
        wr(BASE + 32'h10, 32'h1);
        cycles(10);
        rd_check("count10", BASE + 32'h00, 32'd10);

        // 3: carry from LO into HI
        wr(BASE + 32'h10, 32'h0);
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h04, 32'h0);
        wr(BASE + 32'h10, 32'h1);
        cycles(1);
        rd_check("carry_lo", BASE + 32'h00, 32'h0);
        rd_check("carry_hi", BASE + 32'h04, 32'h1);

        // 4: interrupt rise and fall
        wr(BASE + 32'h10, 32'h0);
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h04, 32'h0);
        wr(BASE + 32'h0C, 32'h0);
        wr(BASE + 32'h08, 32'd5);
        wr(BASE + 32'h10, 32'h1);
        cycles(5);
        rd_check("irq_mtime5", BASE + 32'h00, 32'd5);
        check("irq_before", {31'h0, timer_interrupt}, 32'h0);
        cycles(1);
        check("irq_rise", {31'h0, timer_interrupt}, 32'h1);
        rd_check("ctrl_status", BASE + 32'h10, 32'h3);
        wr(BASE + 32'h08, 32'd100);
        check("irq_hold", {31'h0, timer_interrupt}, 32'h1);
        cycles(1);
        check("irq_fall", {31'h0, timer_interrupt}, 32'h0);

        // 5: prescale 3 -> one increment per 4 cycles; store beats tick
        wr(BASE + 32'h10, 32'h0);
        wr(BASE + 32'h14, 32'd3);
        wr(BASE + 32'h00, 32'h0);
        wr(BASE + 32'h04, 32'h0);
        rd_check("ps_readback", BASE + 32'h14, 32'd3);
        wr(BASE + 32'h10, 32'h1);
        cycles(3);
        rd_check("ps_e3", BASE + 32'h00, 32'd0);
        cycles(1);
        rd_check("ps_e4", BASE + 32'h00, 32'd1);
        cycles(3);
        rd_check("ps_e7", BASE + 32'h00, 32'd1);
        cycles(1);
        rd_check("ps_e8", BASE + 32'h00, 32'd2);
        cycles(3);
        wr(BASE + 32'h00, 32'd7);
        rd_check("ps_store_lo", BASE + 32'h00, 32'd7);
        rd_check("ps_store_hi", BASE + 32'h04, 32'd0);

        // 6: reset with interrupt asserted and mtime=0x1234
        wr(BASE + 32'h10, 32'h0);
        wr(BASE + 32'h14, 32'hFFFF);
        wr(BASE + 32'h00, 32'h1234);
        wr(BASE + 32'h0C, 32'h0);
        wr(BASE + 32'h08, 32'h0);
        wr(BASE + 32'h10, 32'h1);
        cycles(1);
        check("pre_rst_irq", {31'h0, timer_interrupt}, 32'h1);
        rd_check("pre_rst_mtime", BASE + 32'h00, 32'h1234);
        do_reset();
        check("post_rst_irq", {31'h0, timer_interrupt}, 32'h0);
        run_table("post_rst");

        // misaligned and out-of-window stores are ignored
        wr(BASE + 32'h02, 32'hFFFF_FFFF);
        wr(BASE + 32'h40, 32'hFFFF_FFFF);
        wr(BASE + 32'h50, 32'hFFFF_FFFF);
        wr(BASE + 32'h56, 32'hFFFF_FFFF);
        wr(BASE + 32'h19, 32'hFFFF_FFFF);
        cycles(2);
        run_table("bad_store");
        check("bad_store_irq", {31'h0, timer_interrupt}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
